mem_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single-port 64x16 front-door memory.
- Accepts a valid/ready transaction from requester 0 or 1 and latches it.
- Drives a one-cycle valid pulse into the memory, waits for the memory's ready, then returns read data or completion to the granted requester.
- A bounded wait timeout turns a stalled memory into an error completion, so neither requester hangs.

---
 rtl/mem_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-requester round-robin front end for a single-port memory.
// One transaction is in flight at a time: IDLE latches a winner, ISSUE pulses
// the memory strobe, WAIT collects the response (or times out), DONE returns
// a one-cycle completion pulse to the granted requester.
module mem_rr_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  r0_valid_i,
    input  logic                  r0_w_r_i,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [WIDTH-1:0]      r0_wdata_i,
    output logic                  r0_ready_o,
    output logic [WIDTH-1:0]      r0_rdata_o,
    output logic                  r0_err_o,

    input  logic                  r1_valid_i,
    input  logic                  r1_w_r_i,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [WIDTH-1:0]      r1_wdata_i,
    output logic                  r1_ready_o,
    output logic [WIDTH-1:0]      r1_rdata_o,
    output logic                  r1_err_o,

    output logic                  m_valid_o,
    output logic                  m_w_r_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [WIDTH-1:0]      m_wdata_o,
    input  logic                  m_ready_i,
    input  logic [WIDTH-1:0]      m_rdata_i,

    output logic                  busy_o,
    output logic                  grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] count;
    logic             any_valid;
    logic             pick;

    // Round-robin choice: on a tie the requester not served last goes next
    always_comb begin
        any_valid = r0_valid_i | r1_valid_i;
        if (r0_valid_i && r1_valid_i) begin
            pick = ~last;
        end else begin
            pick = r1_valid_i;
        end
    end

    // Sequencer FSM; the m_* outputs double as the latched transaction fields
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            last       <= 1'b1;
            count      <= '0;
            grant_o    <= 1'b0;
            busy_o     <= 1'b0;
            m_valid_o  <= 1'b0;
            m_w_r_o    <= 1'b0;
            m_addr_o   <= '0;
            m_wdata_o  <= '0;
            r0_ready_o <= 1'b0;
            r0_err_o   <= 1'b0;
            r0_rdata_o <= '0;
            r1_ready_o <= 1'b0;
            r1_err_o   <= 1'b0;
            r1_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_o   <= pick;
                        m_w_r_o   <= pick ? r1_w_r_i   : r0_w_r_i;
                        m_addr_o  <= pick ? r1_addr_i  : r0_addr_i;
                        m_wdata_o <= pick ? r1_wdata_i : r0_wdata_i;
                        m_valid_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_valid_o <= 1'b0;
                    count     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (m_ready_i) begin
                        if (!m_w_r_o) begin
                            if (grant_o) begin
                                r1_rdata_o <= m_rdata_i;
                            end else begin
                                r0_rdata_o <= m_rdata_i;
                            end
                        end
                        r0_ready_o <= ~grant_o;
                        r1_ready_o <= grant_o;
                        r0_err_o   <= 1'b0;
                        r1_err_o   <= 1'b0;
                        state      <= DONE;
                    end else if (count == CNT_W'(TIMEOUT - 1)) begin
                        r0_ready_o <= ~grant_o;
                        r1_ready_o <= grant_o;
                        r0_err_o   <= ~grant_o;
                        r1_err_o   <= grant_o;
                        state      <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    r0_ready_o <= 1'b0;
                    r1_ready_o <= 1'b0;
                    r0_err_o   <= 1'b0;
                    r1_err_o   <= 1'b0;
                    last       <= grant_o;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed and randomized checks of mem_rr_arbiter against
// a transaction-level reference model (grant order, data, error, latency).
module tb_mem_rr_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_w_r, r0_ready, r0_err;
    logic [5:0]  r0_addr;
    logic [15:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_w_r, r1_ready, r1_err;
    logic [5:0]  r1_addr;
    logic [15:0] r1_wdata, r1_rdata;
    logic        m_valid, m_w_r, m_ready, mem_ready;
    logic [5:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic        busy, grant;
    logic        stall, force_ready;

    logic [15:0] mem [64];
    bit          mem_written [64];

    logic [15:0] ref_mem [int];
    logic [15:0] ref_rdata [2];
    int          ref_last;

    int checks;
    int errors;

    mem_rr_arbiter #(.WIDTH(16), .ADDR_WIDTH(6), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .r0_valid_i (r0_valid),
        .r0_w_r_i   (r0_w_r),
        .r0_addr_i  (r0_addr),
        .r0_wdata_i (r0_wdata),
        .r0_ready_o (r0_ready),
        .r0_rdata_o (r0_rdata),
        .r0_err_o   (r0_err),
        .r1_valid_i (r1_valid),
        .r1_w_r_i   (r1_w_r),
        .r1_addr_i  (r1_addr),
        .r1_wdata_i (r1_wdata),
        .r1_ready_o (r1_ready),
        .r1_rdata_o (r1_rdata),
        .r1_err_o   (r1_err),
        .m_valid_o  (m_valid),
        .m_w_r_o    (m_w_r),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_ready_i  (m_ready),
        .m_rdata_i  (m_rdata),
        .busy_o     (busy),
        .grant_o    (grant)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on content of memory locations that were never written
    function automatic logic [15:0] fill(input logic [5:0] a);
        return {10'h2A5, a};
    endfunction

    // Memory responds one cycle after an accepted strobe unless stalled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            m_rdata   <= '0;
        end else begin
            mem_ready <= m_valid && !stall;
            if (m_valid && !stall) begin
                if (m_w_r) begin
                    mem[m_addr]         <= m_wdata;
                    mem_written[m_addr] <= 1'b1;
                end else begin
                    m_rdata <= mem_written[m_addr] ? mem[m_addr] : fill(m_addr);
                end
            end
        end
    end

    assign m_ready = mem_ready | force_ready;

    // Count one comparison and report it if it does not hold
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one requester's request fields
    task automatic apply_stimulus(input int req, input logic valid, input logic w_r,
                                  input logic [5:0] addr, input logic [15:0] wdata);
        if (req == 0) begin
            r0_valid = valid; r0_w_r = w_r; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_valid = valid; r1_w_r = w_r; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // Predict the next completion from the held requests, wait for it and check it.
    // extra = 1 when called from the DONE cycle of the previous transaction.
    task automatic serve_one(input int extra, output int who);
        int          exp_who, exp_cycles, cycles, pulses;
        bit          seen, exp_err;
        logic        exp_wr;
        logic [5:0]  exp_addr;
        logic [15:0] exp_wdata;
        if (r0_valid && r1_valid) exp_who = (ref_last == 0) ? 1 : 0;
        else                      exp_who = r1_valid ? 1 : 0;
        exp_wr     = exp_who == 1 ? r1_w_r    : r0_w_r;
        exp_addr   = exp_who == 1 ? r1_addr   : r0_addr;
        exp_wdata  = exp_who == 1 ? r1_wdata  : r0_wdata;
        exp_err    = stall;
        exp_cycles = extra + (stall ? 2 + TIMEOUT : 3);
        cycles = 0; pulses = 0; seen = 0;
        who = exp_who;
        while (!seen && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (m_valid) begin
                pulses++;
                check_output("m_addr", 32'(m_addr), 32'(exp_addr));
                check_output("m_w_r", 32'(m_w_r), 32'(exp_wr));
                if (exp_wr) check_output("m_wdata", 32'(m_wdata), 32'(exp_wdata));
            end
            if (r0_ready || r1_ready) seen = 1;
        end
        check_output("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            who = r1_ready ? 1 : 0;
            check_output("winner", 32'(who), 32'(exp_who));
            check_output("no_overlap", 32'(r0_ready & r1_ready), 32'd0);
            check_output("grant", 32'(grant), 32'(exp_who));
            check_output("latency", 32'(cycles), 32'(exp_cycles));
            check_output("m_valid_pulses", 32'(pulses), 32'd1);
            check_output("err_winner", 32'(exp_who == 1 ? r1_err : r0_err), 32'(exp_err));
            check_output("err_other", 32'(exp_who == 1 ? r0_err : r1_err), 32'd0);
            if (!exp_err) begin
                if (exp_wr) begin
                    ref_mem[int'(exp_addr)] = exp_wdata;
                end else begin
                    ref_rdata[exp_who] = ref_mem.exists(int'(exp_addr)) ? ref_mem[int'(exp_addr)] : fill(exp_addr);
                end
            end
            check_output("rdata_r0", 32'(r0_rdata), 32'(ref_rdata[0]));
            check_output("rdata_r1", 32'(r1_rdata), 32'(ref_rdata[1]));
            ref_last = exp_who;
        end
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        int          who;
        int          idx [2];
        logic        tw [2][3];
        logic [5:0]  ta [2][3];
        logic [15:0] td [2][3];
        int          pat;
        logic        rw;
        logic [5:0]  ra;
        logic [15:0] rd;

        checks = 0; errors = 0;
        ref_last = 1; ref_rdata[0] = '0; ref_rdata[1] = '0;
        stall = 1'b0; force_ready = 1'b0;
        rst_n = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, 6'd0, 16'h0);
        apply_stimulus(1, 1'b0, 1'b0, 6'd0, 16'h0);
        $display("[TB] reset");
        repeat (2) @(negedge clk);
        check_output("reset_outputs", 32'({m_valid, m_w_r, m_addr, m_wdata, busy, grant,
                                           r0_ready, r0_err, r1_ready, r1_err}), 32'd0);
        check_output("reset_rdata", {r0_rdata, r1_rdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] simultaneous reads from reset");
        apply_stimulus(0, 1'b1, 1'b0, 6'd1, 16'h0);
        apply_stimulus(1, 1'b1, 1'b0, 6'd2, 16'h0);
        serve_one(0, who);
        check_output("tie_first", 32'(who), 32'd0);
        apply_stimulus(who, 1'b0, 1'b0, 6'd0, 16'h0);
        serve_one(1, who);
        check_output("tie_second", 32'(who), 32'd1);
        apply_stimulus(who, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);

        $display("[TB] r0 write then read addr 5");
        apply_stimulus(0, 1'b1, 1'b1, 6'd5, 16'hA5A5);
        serve_one(0, who);
        apply_stimulus(0, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);
        apply_stimulus(0, 1'b1, 1'b0, 6'd5, 16'h0);
        serve_one(0, who);
        check_output("rd5_data", 32'(r0_rdata), 32'h0000A5A5);
        apply_stimulus(0, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);

        $display("[TB] alternating held requests");
        apply_stimulus(1, 1'b1, 1'b0, 6'd9, 16'h0);
        serve_one(0, who);
        apply_stimulus(1, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);
        tw[0][0] = 1'b0; ta[0][0] = 6'd10; td[0][0] = 16'h0;
        tw[0][1] = 1'b0; ta[0][1] = 6'd63; td[0][1] = 16'h0;
        tw[0][2] = 1'b1; ta[0][2] = 6'd7;  td[0][2] = 16'h1234;
        tw[1][0] = 1'b1; ta[1][0] = 6'd63; td[1][0] = 16'hFFFF;
        tw[1][1] = 1'b0; ta[1][1] = 6'd7;  td[1][1] = 16'h0;
        tw[1][2] = 1'b0; ta[1][2] = 6'd7;  td[1][2] = 16'h0;
        idx[0] = 0; idx[1] = 0;
        apply_stimulus(0, 1'b1, tw[0][0], ta[0][0], td[0][0]);
        apply_stimulus(1, 1'b1, tw[1][0], ta[1][0], td[1][0]);
        for (int k = 0; k < 6; k++) begin
            serve_one(k == 0 ? 0 : 1, who);
            check_output("alt_grant", 32'(who), 32'(k % 2));
            if (k == 2) check_output("rd63_data", 32'(r0_rdata), 32'h0000FFFF);
            idx[who]++;
            if (idx[who] < 3) apply_stimulus(who, 1'b1, tw[who][idx[who]], ta[who][idx[who]], td[who][idx[who]]);
            else              apply_stimulus(who, 1'b0, 1'b0, 6'd0, 16'h0);
        end
        check_output("rd7_data", 32'(r1_rdata), 32'h00001234);
        @(negedge clk);

        $display("[TB] stalled memory on r1 read");
        stall = 1'b1;
        apply_stimulus(1, 1'b1, 1'b0, 6'd20, 16'h0);
        serve_one(0, who);
        check_output("timeout_err", 32'(r1_err), 32'd1);
        stall = 1'b0;
        apply_stimulus(1, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);
        apply_stimulus(0, 1'b1, 1'b0, 6'd63, 16'h0);
        serve_one(0, who);
        check_output("after_timeout", 32'(r0_rdata), 32'h0000FFFF);
        apply_stimulus(0, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);

        $display("[TB] reset during WAIT");
        stall = 1'b1;
        apply_stimulus(1, 1'b1, 1'b0, 6'd3, 16'hBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("in_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("async_outputs", 32'({m_valid, m_w_r, m_addr, m_wdata, busy, grant,
                                           r0_ready, r0_err, r1_ready, r1_err}), 32'd0);
        check_output("async_rdata", {r0_rdata, r1_rdata}, 32'd0);
        ref_last = 1; ref_rdata[0] = '0; ref_rdata[1] = '0;
        stall = 1'b0;
        apply_stimulus(1, 1'b0, 1'b0, 6'd0, 16'h0);
        repeat (2) begin
            @(negedge clk);
            check_output("reset_no_ready", 32'({r0_ready, r1_ready}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 1'b1, 1'b0, 6'd4, 16'h0);
        apply_stimulus(1, 1'b1, 1'b0, 6'd5, 16'h0);
        serve_one(0, who);
        check_output("post_reset_tie", 32'(who), 32'd0);
        apply_stimulus(0, 1'b0, 1'b0, 6'd0, 16'h0);
        serve_one(1, who);
        apply_stimulus(1, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);

        $display("[TB] spurious memory ready while idle");
        force_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("spurious_idle", 32'({busy, m_valid, r0_ready, r1_ready}), 32'd0);
        end
        force_ready = 1'b0;
        @(negedge clk);
        apply_stimulus(1, 1'b1, 1'b0, 6'd5, 16'h0);
        serve_one(0, who);
        apply_stimulus(1, 1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 16; it++) begin
            pat = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                rw = 1'($urandom_range(0, 1));
                ra = 6'($urandom_range(0, 7));
                rd = 16'($urandom);
                apply_stimulus(r, pat[r], rw, ra, rd);
            end
            serve_one(0, who);
            apply_stimulus(who, 1'b0, 1'b0, 6'd0, 16'h0);
            if (r0_valid || r1_valid) begin
                serve_one(1, who);
                apply_stimulus(who, 1'b0, 1'b0, 6'd0, 16'h0);
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
